bp_io_loopback_gen: RTL
=======================

# bp_io_loopback_gen

Parametrised IO traffic generator and loopback responder for bring-up of the FPGA host on Arty. It drives bursts of uncached putchar writes into the host's inbound IO command port and answers the host's outbound IO commands locally, so the host can be exercised without a BlackParrot core attached. It generalises the single-byte, single-outstanding test harness in four ways: configurable data width, burst length, outstanding-request depth and reset-stretch length. It also adds error detection.

## Interface
- paddr_width_p, 40: physical address width.
- data_width_p, 64: command/response data width; power of two, 8..64.
- burst_len_p, 16: commands issued per start pulse; at least 1.
- outstanding_p, 4: maximum write commands awaiting response; at least 1.
- putchar_addr_p, 40'h0010_1000: address of generated writes.
- readback_addr_p, 40'h0010_2000: host-write address that updates the read byte (only under the macro).
- resp_byte_p, 8'h00: reset value of the read byte.
- reset_cycles_p, 16384: stretch length of the internal reset.
- clk_i  in  1  sole clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- start_i  in  1  single-cycle pulse (already debounced) that starts one burst.
- reset_o  out  1  stretched internal reset, active-high.
- busy_o  out  1  burst in progress.
- error_o  out  1  sticky protocol error.
- out_cmd_v_o / out_cmd_ready_and_i  out/in  1/1  generated-command handshake, valid→ready.
- out_cmd_type_o  out  4  bp_bedrock_mem_type_e; always e_bedrock_mem_uc_wr (4'd3).
- out_cmd_addr_o  out  paddr_width_p  always putchar_addr_p.
- out_cmd_size_o  out  3  log2(data_width_p/8).
- out_cmd_data_o  out  data_width_p  byte counter replicated into every byte lane.
- out_resp_v_i / out_resp_yumi_o  in/out  1/1  response to generated commands.
- out_resp_type_i  in  4  response type.
- in_cmd_v_i / in_cmd_yumi_o  in/out  1/1  host-originated command.
- in_cmd_type_i, in_cmd_addr_i, in_cmd_size_i, in_cmd_data_i  in  4/paddr_width_p/3/data_width_p  fields of the host command.
- in_resp_v_o / in_resp_ready_and_i  out/in  1/1  response to the host, valid→ready.
- in_resp_type_o, in_resp_addr_o, in_resp_size_o, in_resp_data_o  out  same widths as the matching in_cmd fields.

## Operation
- **Reset stretcher**
  - reset_n_i low asynchronously forces: reset_o=1, all state cleared, all valids/yumis=0, error_o=0, byte counter=0, read byte=resp_byte_p.
  - Release passes through a 2-flop synchroniser. After it, a counter runs for reset_cycles_p cycles, then reset_o falls.
  - While reset_o=1, both engines are idle and start_i is ignored.
- **Generator FSM: e_ready, e_send, e_drain**
  - e_ready: start_i → e_send; sent counter := 0.
  - e_send: out_cmd_v_o=1 while outstanding < outstanding_p. On handshake: sent++, byte counter +1 (8-bit, wraps 0xFF→0x00), outstanding++. The handshake that makes sent == burst_len_p → e_drain.
  - e_drain: when outstanding == 0 → e_ready.
  - busy_o = (state != e_ready).
  - start_i outside e_ready is ignored, not queued.
- **Outstanding counter**
  - Width clog2(outstanding_p+1).
  - out_resp_yumi_o = out_resp_v_i; every response is consumed immediately.
  - Issue and retire in the same cycle: count unchanged.
  - Response while outstanding == 0: error_o set, count stays 0.
  - Response with type != uc_wr: error_o set; the response still retires one credit.
- **Responder (combinational, no buffering)**
  - in_resp_v_o = in_cmd_v_i.
  - in_cmd_yumi_o = in_cmd_v_i & in_resp_ready_and_i.
  - type, addr and size are echoed from the command.
  - uc_rd: data = zero-extended read byte in bits [7:0].
  - uc_wr: data echoes in_cmd_data_i.
  - Any other type: echoed as for uc_wr, and error_o set on yumi.

## Timing
- Generated command is visible the cycle after start_i is sampled.
- Back-to-back commands: one per cycle while credits remain.
- Responder latency is 0 cycles; no combinational path from in_resp_ready_and_i to in_resp_v_o.
- error_o rises the cycle after the offending handshake and holds until reset.
- reset_n_i asserted mid-burst: outstanding transactions are abandoned; late responses arriving after reset are flagged by error_o.

## Configuration
- IO_LOOPBACK_READBACK_EN defined:
  - A host uc_wr to readback_addr_p loads in_cmd_data_i[7:0] into the read byte on yumi.
  - A subsequent uc_rd returns the new value.
- Undefined: the read byte is the constant resp_byte_p, and writes to readback_addr_p are plain echoes.

## Test plan
- **Reset release:** reset_n_i low 5 cycles, then high → reset_o high for exactly reset_cycles_p+2 cycles after release; all valids 0 throughout.
- **Burst flow:** burst_len_p=4, outstanding_p=2, responses 3 cycles after each command → data lanes 0x00, 0x01, 0x02, 0x03; never more than 2 outstanding; busy_o falls after the 4th response.
- **Backpressure and wrap:** out_cmd_ready_and_i low 10 cycles, byte counter preset to 0xFE by bursts → data stable while stalled; sequence 0xFE, 0xFF, 0x00.
- **Responder:** host uc_rd with ready_and low 3 cycles → in_cmd_yumi_o only in the ready cycle; data = resp_byte_p; no error.
- **Error detection:** unsolicited uc_rd response with 0 outstanding → error_o=1 next cycle and sticky until reset_n_i.
- **Readback (macro defined):** host uc_wr of 0xA5 to readback_addr_p, then uc_rd → response data 0x00000000000000A5.

Source files
------------

// File: rtl/bp_io_loopback_gen.sv
// bp_io_loopback_gen
//   IO traffic generator and loopback responder for FPGA host bring-up.
//   A start pulse issues burst_len_p uncached writes to putchar_addr_p, with at
//   most outstanding_p awaiting a response. Host-originated IO commands are
//   answered combinationally. Protocol violations set a sticky error_o.
//
//   Optional feature macro: IO_LOOPBACK_READBACK_EN
//     defined   : host uc_wr to readback_addr_p loads the byte returned by uc_rd
//     undefined : uc_rd always returns resp_byte_p
//
// Ports
//   clk_i, reset_n_i          clock, asynchronous active-low reset
//   start_i                   one-cycle pulse, starts a burst
//   reset_o                   stretched internal reset (active-high)
//   busy_o, error_o           burst in progress, sticky protocol error
//   out_cmd_*                 generated command (valid->ready)
//   out_resp_*                responses to generated commands (yumi)
//   in_cmd_*                  host command (yumi)
//   in_resp_*                 response to host (valid->ready)
module bp_io_loopback_gen #(
  parameter int unsigned              paddr_width_p   = 40,
  parameter int unsigned              data_width_p    = 64,
  parameter int unsigned              burst_len_p     = 16,
  parameter int unsigned              outstanding_p   = 4,
  parameter logic [paddr_width_p-1:0] putchar_addr_p  = 40'h00_0010_1000,
  parameter logic [paddr_width_p-1:0] readback_addr_p = 40'h00_0010_2000,
  parameter logic [7:0]               resp_byte_p     = 8'h00,
  parameter int unsigned              reset_cycles_p  = 16384
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     start_i,
  output logic                     reset_o,
  output logic                     busy_o,
  output logic                     error_o,

  output logic                     out_cmd_v_o,
  input  logic                     out_cmd_ready_and_i,
  output logic [3:0]               out_cmd_type_o,
  output logic [paddr_width_p-1:0] out_cmd_addr_o,
  output logic [2:0]               out_cmd_size_o,
  output logic [data_width_p-1:0]  out_cmd_data_o,

  input  logic                     out_resp_v_i,
  output logic                     out_resp_yumi_o,
  input  logic [3:0]               out_resp_type_i,

  input  logic                     in_cmd_v_i,
  output logic                     in_cmd_yumi_o,
  input  logic [3:0]               in_cmd_type_i,
  input  logic [paddr_width_p-1:0] in_cmd_addr_i,
  input  logic [2:0]               in_cmd_size_i,
  input  logic [data_width_p-1:0]  in_cmd_data_i,

  output logic                     in_resp_v_o,
  input  logic                     in_resp_ready_and_i,
  output logic [3:0]               in_resp_type_o,
  output logic [paddr_width_p-1:0] in_resp_addr_o,
  output logic [2:0]               in_resp_size_o,
  output logic [data_width_p-1:0]  in_resp_data_o
);

  typedef enum logic [3:0] {
    e_uc_rd = 4'd2,
    e_uc_wr = 4'd3
  } io_type_e;

  typedef enum logic [1:0] {
    e_ready,
    e_send,
    e_drain
  } state_e;

  localparam int unsigned ocnt_w_lp = $clog2(outstanding_p + 1);
  localparam int unsigned scnt_w_lp = $clog2(burst_len_p + 1);
  localparam int unsigned rcnt_w_lp = (reset_cycles_p > 1) ? $clog2(reset_cycles_p) : 1;
  localparam int unsigned lanes_lp  = data_width_p / 8;

  // ---------------------------------------------------------------------------
  // Reset stretcher: 2-flop release synchroniser, then reset_cycles_p count.
  // ---------------------------------------------------------------------------
  logic [1:0]           rst_sync_r;
  logic [rcnt_w_lp-1:0] rst_cnt_r;
  logic                 reset_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rst_sync_r <= '0;
      rst_cnt_r  <= '0;
      reset_r    <= 1'b1;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
      if (reset_r && rst_sync_r[1]) begin
        if (rst_cnt_r == rcnt_w_lp'(reset_cycles_p - 1))
          reset_r <= 1'b0;
        else
          rst_cnt_r <= rst_cnt_r + 1'b1;
      end
    end
  end

  assign reset_o = reset_r;

  // ---------------------------------------------------------------------------
  // Generator state
  // ---------------------------------------------------------------------------
  state_e               state_r;
  logic [scnt_w_lp-1:0] sent_r;
  logic [ocnt_w_lp-1:0] outst_r;
  logic [ocnt_w_lp-1:0] outst_n;
  logic [7:0]           byte_r;
  logic                 error_r;
  logic [7:0]           read_byte;

  logic cmd_fire;
  logic retire;
  logic err_resp;
  logic err_host;

  assign out_cmd_v_o     = (state_r == e_send) && (outst_r < ocnt_w_lp'(outstanding_p));
  assign out_cmd_type_o  = e_uc_wr;
  assign out_cmd_addr_o  = putchar_addr_p;
  assign out_cmd_size_o  = 3'($clog2(lanes_lp));
  assign out_cmd_data_o  = {lanes_lp{byte_r}};
  assign busy_o          = (state_r != e_ready);
  assign error_o         = error_r;

  // Responses are always consumed, except while the engines are held idle.
  assign out_resp_yumi_o = out_resp_v_i & ~reset_r;
  assign cmd_fire        = out_cmd_v_o & out_cmd_ready_and_i;
  // A response with nothing outstanding is an error and retires no credit.
  assign retire          = out_resp_yumi_o & (outst_r != '0);
  assign err_resp        = out_resp_yumi_o
                         & ((outst_r == '0) || (out_resp_type_i != e_uc_wr));
  assign err_host        = in_cmd_yumi_o
                         & (in_cmd_type_i != e_uc_rd) & (in_cmd_type_i != e_uc_wr);

  always_comb begin
    outst_n = outst_r;
    if (cmd_fire && !retire)
      outst_n = outst_r + 1'b1;
    else if (!cmd_fire && retire)
      outst_n = outst_r - 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= e_ready;
      sent_r  <= '0;
      outst_r <= '0;
      byte_r  <= '0;
      error_r <= 1'b0;
    end else begin
      if (err_resp || err_host)
        error_r <= 1'b1;
      if (reset_r) begin
        state_r <= e_ready;
        sent_r  <= '0;
        outst_r <= '0;
      end else begin
        outst_r <= outst_n;
        if (cmd_fire)
          byte_r <= byte_r + 8'd1;
        case (state_r)
          e_ready: begin
            if (start_i) begin
              state_r <= e_send;
              sent_r  <= '0;
            end
          end
          e_send: begin
            if (cmd_fire) begin
              sent_r <= sent_r + 1'b1;
              if (sent_r == scnt_w_lp'(burst_len_p - 1))
                state_r <= e_drain;
            end
          end
          e_drain: begin
            // Look at the post-retire count so busy_o drops right after the
            // final response rather than one cycle later.
            if (outst_n == '0)
              state_r <= e_ready;
          end
          default: state_r <= e_ready;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Responder: combinational echo, no buffering.
  // ---------------------------------------------------------------------------
  assign in_resp_v_o    = in_cmd_v_i & ~reset_r;
  assign in_cmd_yumi_o  = in_resp_v_o & in_resp_ready_and_i;
  assign in_resp_type_o = in_cmd_type_i;
  assign in_resp_addr_o = in_cmd_addr_i;
  assign in_resp_size_o = in_cmd_size_i;

  always_comb begin
    in_resp_data_o = in_cmd_data_i;
    if (in_cmd_type_i == e_uc_rd)
      in_resp_data_o = data_width_p'(read_byte);
  end

`ifdef IO_LOOPBACK_READBACK_EN
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)
      read_byte <= resp_byte_p;
    else if (in_cmd_yumi_o && (in_cmd_type_i == e_uc_wr)
             && (in_cmd_addr_i == readback_addr_p))
      read_byte <= in_cmd_data_i[7:0];
  end
`else
  assign read_byte = resp_byte_p;
`endif

endmodule
